// File: rtl/im_loader.sv
// Serial boot loader: receives framed instruction words over a byte stream and
// writes them into the 17-bit instruction memory while holding the CPU off.
module im_loader #(
  parameter int          IM_DEPTH  = 8192,
  parameter logic [7:0]  SYNC_BYTE = 8'hA5
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        rx_rdy,
  input  logic [7:0]  rx_data,
  output logic        im_we,
  output logic [15:0] im_addr,
  output logic [16:0] im_wdata,
  output logic        cpu_hold,
  output logic        done,
  output logic        err
);

  typedef enum logic [2:0] {
    IDLE,
    LEN_LO,
    LEN_HI,
    W0,
    W1,
    W2,
    CHK
  } state_t;

  state_t      state_q, state_d;
  logic [7:0]  len_lo_q;
  logic [15:0] len_q;
  logic [15:0] word_idx_q;
  logic [7:0]  chk_q;
  logic [7:0]  b0_q, b1_q;

  // Control decoded from the current state and byte
  logic        start, fail, pass, write;
  logic        cap_lo, cap_len, cap_b0, cap_b1, adv_idx, chk_upd;
  logic [15:0] len_full;
  logic        last_word;

  assign len_full  = {rx_data, len_lo_q};
  assign last_word = (word_idx_q == len_q - 16'd1);

  // NOTE: every always_comb output gets a default first so no path leaves it
  // unassigned; otherwise synthesis infers a latch to hold the old value.
  always_comb begin
    state_d = state_q;
    start   = 1'b0;
    fail    = 1'b0;
    pass    = 1'b0;
    write   = 1'b0;
    cap_lo  = 1'b0;
    cap_len = 1'b0;
    cap_b0  = 1'b0;
    cap_b1  = 1'b0;
    adv_idx = 1'b0;
    chk_upd = 1'b0;
    if (rx_rdy) begin
      unique case (state_q)
        IDLE: begin
          if (rx_data == SYNC_BYTE) begin
            start   = 1'b1;
            state_d = LEN_LO;
          end
        end
        LEN_LO: begin
          cap_lo  = 1'b1;
          chk_upd = 1'b1;
          state_d = LEN_HI;
        end
        LEN_HI: begin
          chk_upd = 1'b1;
          // Oversized frames are refused before any word reaches memory
          if (32'(len_full) > 32'(IM_DEPTH)) begin
            fail    = 1'b1;
            state_d = IDLE;
          end else begin
            cap_len = 1'b1;
            state_d = (len_full == 16'd0) ? CHK : W0;
          end
        end
        W0: begin
          cap_b0  = 1'b1;
          chk_upd = 1'b1;
          state_d = W1;
        end
        W1: begin
          cap_b1  = 1'b1;
          chk_upd = 1'b1;
          state_d = W2;
        end
        W2: begin
          if (rx_data[7:1] != 7'd0) begin
            fail    = 1'b1;
            state_d = IDLE;
          end else begin
            write   = 1'b1;
            chk_upd = 1'b1;
            if (last_word) begin
              state_d = CHK;
            end else begin
              adv_idx = 1'b1;
              state_d = W0;
            end
          end
        end
        CHK: begin
          if (rx_data == chk_q) pass = 1'b1;
          else                  fail = 1'b1;
          state_d = IDLE;
        end
        default: state_d = IDLE;
      endcase
    end
  end

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values, independent of statement order.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= IDLE;
      im_we      <= 1'b0;
      im_addr    <= 16'd0;
      im_wdata   <= 17'd0;
      cpu_hold   <= 1'b0;
      done       <= 1'b0;
      err        <= 1'b0;
      word_idx_q <= 16'd0;
      chk_q      <= 8'd0;
      len_lo_q   <= 8'd0;
      len_q      <= 16'd0;
      b0_q       <= 8'd0;
      b1_q       <= 8'd0;
    end else begin
      state_q <= state_d;
      im_we   <= write;
      // Address/data stay put between strobes
      if (write) begin
        im_addr  <= word_idx_q;
        im_wdata <= {rx_data[0], b1_q, b0_q};
      end
      if (start) begin
        done       <= 1'b0;
        err        <= 1'b0;
        cpu_hold   <= 1'b1;
        chk_q      <= 8'd0;
        word_idx_q <= 16'd0;
      end
      if (chk_upd) chk_q      <= chk_q ^ rx_data;
      if (cap_lo)  len_lo_q   <= rx_data;
      if (cap_len) len_q      <= len_full;
      if (cap_b0)  b0_q       <= rx_data;
      if (cap_b1)  b1_q       <= rx_data;
      if (adv_idx) word_idx_q <= word_idx_q + 16'd1;
      if (fail) begin
        err      <= 1'b1;
        done     <= 1'b0;
        cpu_hold <= 1'b0;
      end
      if (pass) begin
        done     <= 1'b1;
        cpu_hold <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_im_loader.sv
// Self-checking bench for im_loader: table of frames with expected writes and
// final flags, plus hand sequences for reset-abort and flag clearing.
module tb_im_loader;

  logic        clk = 1'b0;
  logic        rst;
  logic        rx_rdy;
  logic [7:0]  rx_data;
  logic        im_we;
  logic [15:0] im_addr;
  logic [16:0] im_wdata;
  logic        cpu_hold;
  logic        done;
  logic        err;

  int checks = 0;
  int errors = 0;

  im_loader dut (
    .clk      (clk),
    .rst      (rst),
    .rx_rdy   (rx_rdy),
    .rx_data  (rx_data),
    .im_we    (im_we),
    .im_addr  (im_addr),
    .im_wdata (im_wdata),
    .cpu_hold (cpu_hold),
    .done     (done),
    .err      (err)
  );

  always #5 clk = ~clk;

  // Bytes right-aligned: byte i of n sits at [8*(n-1-i) +: 8]; writes are {addr,data}
  typedef struct {
    int           n;
    logic [127:0] bytes;
    int           nw;
    logic [131:0] wr;
    logic         exp_done;
    logic         exp_err;
  } vec_t;

  vec_t        vecs[8];
  logic [32:0] exp_q[$];

  task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  always @(negedge clk) begin
    if (im_we) begin
      if (exp_q.size() == 0) begin
        check("unexpected_write", 64'(im_addr), 64'hFFFF_FFFF);
      end else begin
        logic [32:0] e;
        e = exp_q.pop_front();
        check("wr_addr", 64'(im_addr), 64'(e[32:17]));
        check("wr_data", 64'(im_wdata), 64'(e[16:0]));
      end
    end
  end

  task automatic send_byte(input logic [7:0] b);
    repeat ($urandom_range(0, 2)) @(posedge clk);
    @(posedge clk);
    #1;
    rx_rdy  = 1'b1;
    rx_data = b;
    @(posedge clk);
    #1;
    rx_rdy  = 1'b0;
    rx_data = 8'h00;
  endtask

  task automatic apply_vec(input int k);
    for (int j = 0; j < vecs[k].nw; j++)
      exp_q.push_back(vecs[k].wr[33*(vecs[k].nw-1-j) +: 33]);
    for (int i = 0; i < vecs[k].n; i++)
      send_byte(vecs[k].bytes[8*(vecs[k].n-1-i) +: 8]);
    repeat (3) @(posedge clk);
    @(negedge clk);
    check($sformatf("v%0d_pending_writes", k), 64'(exp_q.size()), 64'd0);
    check($sformatf("v%0d_done", k), 64'(done), 64'(vecs[k].exp_done));
    check($sformatf("v%0d_err", k), 64'(err), 64'(vecs[k].exp_err));
    check($sformatf("v%0d_cpu_hold", k), 64'(cpu_hold), 64'd0);
    check($sformatf("v%0d_done_err_excl", k), 64'(done & err), 64'd0);
    exp_q.delete();
  endtask

  initial begin
    // Good two-word frame, checksum 02^00^34^12^01^CD^AB^00 = 43
    vecs[0] = '{10, 128'({8'hA5, 8'h02, 8'h00, 8'h34, 8'h12, 8'h01, 8'hCD, 8'hAB, 8'h00, 8'h43}),
                2, 132'({16'd0, 17'h11234, 16'd1, 17'h0ABCD}), 1'b1, 1'b0};
    // Same frame, inverted checksum
    vecs[1] = '{10, 128'({8'hA5, 8'h02, 8'h00, 8'h34, 8'h12, 8'h01, 8'hCD, 8'hAB, 8'h00, 8'hBC}),
                2, 132'({16'd0, 17'h11234, 16'd1, 17'h0ABCD}), 1'b0, 1'b1};
    // LEN = 8193, one past depth
    vecs[2] = '{3, 128'({8'hA5, 8'h01, 8'h20}), 0, 132'd0, 1'b0, 1'b1};
    // Good one-word frame, checksum 01^00^78^56^01 = 2E
    vecs[3] = '{7, 128'({8'hA5, 8'h01, 8'h00, 8'h78, 8'h56, 8'h01, 8'h2E}),
                1, 132'({16'd0, 17'h15678}), 1'b1, 1'b0};
    // Bad B2 byte on the only word
    vecs[4] = '{6, 128'({8'hA5, 8'h01, 8'h00, 8'h11, 8'h22, 8'h02}), 0, 132'd0, 1'b0, 1'b1};
    // Leading junk then empty frame
    vecs[5] = '{6, 128'({8'h00, 8'hFF, 8'hA5, 8'h00, 8'h00, 8'h00}), 0, 132'd0, 1'b1, 1'b0};
    // SYNC value inside payload, checksum 01^00^A5^00^01 = A5
    vecs[6] = '{7, 128'({8'hA5, 8'h01, 8'h00, 8'hA5, 8'h00, 8'h01, 8'hA5}),
                1, 132'({16'd0, 17'h100A5}), 1'b1, 1'b0};
    // First word written, second word has bad B2: no rollback
    vecs[7] = '{9, 128'({8'hA5, 8'h02, 8'h00, 8'h01, 8'h02, 8'h00, 8'h03, 8'h04, 8'h80}),
                1, 132'({16'd0, 17'h00201}), 1'b0, 1'b1};

    rst     = 1'b1;
    rx_rdy  = 1'b0;
    rx_data = 8'h00;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    check("reset_outputs", 64'({im_we, im_addr, im_wdata, cpu_hold, done, err}), 64'd0);

    for (int k = 0; k < 8; k++) begin
      apply_vec(k);
      if (k == 0) begin
        check("hold_addr", 64'(im_addr), 64'd1);
        check("hold_wdata", 64'(im_wdata), 64'h0ABCD);
      end
    end

    // Sync clears sticky err and raises cpu_hold
    send_byte(8'hA5);
    send_byte(8'h02);
    @(negedge clk);
    check("sync_clears_err", 64'(err), 64'd0);
    check("sync_clears_done", 64'(done), 64'd0);
    check("hold_mid_frame", 64'(cpu_hold), 64'd1);

    // Reset after W1 of word 0 aborts with no write
    send_byte(8'h00);
    send_byte(8'h34);
    send_byte(8'h12);
    @(posedge clk);
    #1 rst = 1'b1;
    @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    check("abort_outputs", 64'({im_we, im_addr, im_wdata, cpu_hold, done, err}), 64'd0);
    // Bytes after the abort are ignored until a new sync
    send_byte(8'h01);
    send_byte(8'h00);
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("post_abort_idle", 64'({cpu_hold, done, err}), 64'd0);
    apply_vec(3);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL timeout: simulation did not complete");
    $fatal(1);
  end

endmodule

// File: doc/im_loader.md
IM_LOADER -- requirements
Module: im_loader

Interface
REQ-001 SHALL have parameter IM_DEPTH, default 8192, meaning number of 17-bit instruction-memory words that may be written.
REQ-002 SHALL have parameter SYNC_BYTE, default 8'hA5, meaning the frame start marker.
REQ-003 SHALL have port clk  input  1  system clock; all state changes on posedge clk.
REQ-004 SHALL have port rst  input  1  synchronous, active-high reset.
REQ-005 SHALL have port rx_rdy  input  1  one-cycle pulse: rx_data holds a valid received byte.
REQ-006 SHALL have port rx_data  input  8  received byte.
REQ-007 SHALL have port im_we  output  1  one-cycle instruction-memory write strobe.
REQ-008 SHALL have port im_addr  output  16  instruction-memory write address.
REQ-009 SHALL have port im_wdata  output  17  instruction word to write.
REQ-010 SHALL have port cpu_hold  output  1  high while a frame is being loaded; holds the CPU off instruction memory.
REQ-011 SHALL have port done  output  1  sticky: last frame loaded with a good checksum.
REQ-012 SHALL have port err  output  1  sticky: last frame rejected.

Function
REQ-013 Frame format SHALL be: SYNC_BYTE, LEN_LO, LEN_HI, then LEN words of 3 bytes each (B0=instr[7:0], B1=instr[15:8], B2 bit0=instr[16]), then CHK.
REQ-014 States SHALL be IDLE, LEN_LO, LEN_HI, W0, W1, W2, CHK; a state advances only on a cycle with rx_rdy=1.
REQ-015 IDLE: byte==SYNC_BYTE -> LEN_LO, clears done and err, sets cpu_hold; any other byte is ignored.
REQ-016 LEN_LO -> LEN_HI; LEN_HI -> W0 if LEN!=0, -> CHK if LEN==0.
REQ-017 LEN>IM_DEPTH SHALL be detected at LEN_HI: set err, clear cpu_hold, return to IDLE, no writes.
REQ-018 W0 -> W1 -> W2; W2 byte with bits[7:1]!=0 SHALL set err, clear cpu_hold, return to IDLE, and issue no write for that word.
REQ-019 On a valid W2 byte, im_we SHALL pulse high exactly the next cycle with im_addr=word index (0,1,2,...) and im_wdata={B2[0],B1,B0}.
REQ-020 After the write of word LEN-1 the FSM SHALL go to CHK, otherwise to W0 with the word index incremented.
REQ-021 Running checksum SHALL be the 8-bit XOR of LEN_LO, LEN_HI and every payload byte; SYNC_BYTE and CHK excluded.
REQ-022 CHK: received byte == running checksum -> done=1, else err=1; in both cases cpu_hold=0 the cycle after, state -> IDLE.
REQ-023 Words already written before an error SHALL remain written (no rollback).
REQ-024 im_addr and im_wdata SHALL hold their last written values when im_we=0.
REQ-025 Word index SHALL be 16 bits and never exceed IM_DEPTH-1 given REQ-017.
REQ-026 rx_rdy=0 cycles between bytes SHALL be allowed in any number; no timeout.
REQ-027 A SYNC_BYTE received mid-frame SHALL be treated as data, not a restart.
REQ-028 done and err SHALL never be high simultaneously.

Reset
REQ-029 rst=1 on a posedge SHALL force state=IDLE, im_we=0, im_addr=0, im_wdata=0, cpu_hold=0, done=0, err=0, word index=0, checksum=0, regardless of frame progress.
REQ-030 rst mid-frame SHALL abort the frame; subsequent bytes are ignored until the next SYNC_BYTE.

Verification
REQ-031 Bytes A5,02,00,34,12,01,CD,AB,00,chk=02^00^34^12^01^CD^AB^00 -> writes addr0=17'h11234, addr1=17'h0ABCD, then done=1, cpu_hold=0.
REQ-032 Same frame with CHK byte inverted -> both writes occur, err=1, done=0.
REQ-033 Bytes A5,01,20 (LEN=8193) -> err=1, no im_we, IDLE; next good frame loads normally.
REQ-034 Bytes A5,01,00,11,22,02 -> err=1, no im_we pulse.
REQ-035 Bytes 00,FF before A5,00,00,00 -> leading bytes ignored, no writes, done=1.
REQ-036 rst asserted after the W1 byte of word 0 -> all outputs 0, no write; following good frame yields done=1.
